mmio_bus_ctrl: RTL and testbench

Single-master MMIO bus controller between the CPU load/store stage and the MMIO peripherals (LEDs, switches, etc.). It registers one CPU access and broadcasts it on the shared peripheral bus. It then waits for the addressed peripheral's mmio_done, returns read data, and raises cpu_ready. Unmapped, misaligned and timed-out accesses complete with cpu_err instead of hanging the CPU.

---
 rtl/mmio_bus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: registers one CPU access, broadcasts it to the
// peripherals and returns data or an error on a one-cycle cpu_ready pulse.
module mmio_bus_ctrl #(
  parameter int N_DEV   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic                cpu_ready,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_err,
  output logic                mmio_read,
  output logic                mmio_write,
  output logic [31:0]         mmio_addr,
  output logic [31:0]         mmio_write_data,
  input  logic [N_DEV-1:0]    dev_work,
  input  logic [N_DEV-1:0]    dev_done,
  input  logic [32*N_DEV-1:0] dev_rdata
);

  localparam int SW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;

  logic          rd_d, wr_d;
  logic [31:0]   addr_d, wdata_d;
  logic          ready_d, err_d;
  logic [31:0]   rdata_d;

  logic          any_work;
  logic [SW-1:0] pick;
  logic          done_sel;
  logic [31:0]   rd_sel;

  // lowest index wins when several devices decode the same address
  always_comb begin
    any_work = |dev_work;
    pick     = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (dev_work[i]) pick = SW'(i);
    end
  end

  always_comb begin
    done_sel = 1'b0;
    rd_sel   = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (sel_q == SW'(i)) begin
        done_sel = dev_done[i];
        rd_sel   = dev_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rd_d    = mmio_read;
    wr_d    = mmio_write;
    addr_d  = mmio_addr;
    wdata_d = mmio_write_data;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_addr[1:0] != 2'b00) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            rd_d    = ~cpu_we;
            wr_d    = cpu_we;
            cnt_d   = '0;
            sel_d   = '0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          if (!any_work) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
          end else begin
            sel_d = pick;
          end
        end else if (done_sel) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = mmio_read ? rd_sel : '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sel_q           <= '0;
      mmio_read       <= 1'b0;
      mmio_write      <= 1'b0;
      mmio_addr       <= '0;
      mmio_write_data <= '0;
      cpu_ready       <= 1'b0;
      cpu_err         <= 1'b0;
      cpu_rdata       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sel_q           <= sel_d;
      mmio_read       <= rd_d;
      mmio_write      <= wr_d;
      mmio_addr       <= addr_d;
      mmio_write_data <= wdata_d;
      cpu_ready       <= ready_d;
      cpu_err         <= err_d;
      cpu_rdata       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl with four behavioural peripherals
// that raise a registered one-cycle done after decoding a strobe.
module tb_mmio_bus_ctrl;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic         mmio_read;
  logic         mmio_write;
  logic [31:0]  mmio_addr;
  logic [31:0]  mmio_write_data;
  logic [3:0]   dev_work;
  logic [3:0]   dev_done;
  logic [127:0] dev_rdata;

  logic [3:0]   done_q = '0;
  logic [3:0]   inj = '0;
  logic [3:0]   mute = '0;
  int           wcnt [4];
  int           ndone = 0;
  int           errors = 0;
  int           checks = 0;

  localparam logic [31:0] A_D0 = 32'hFFFF_0000;
  localparam logic [31:0] A_D1 = 32'hFFFF_0084;
  localparam logic [31:0] A_D2 = 32'hFFFF_0088;
  localparam logic [31:0] A_D3 = 32'hFFFF_000C;
  localparam logic [31:0] A_MM = 32'hFFFF_0100;

  always #5 sys_clk = ~sys_clk;

  mmio_bus_ctrl #(
    .N_DEV(4),
    .TIMEOUT(16)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err),
    .mmio_read(mmio_read),
    .mmio_write(mmio_write),
    .mmio_addr(mmio_addr),
    .mmio_write_data(mmio_write_data),
    .dev_work(dev_work),
    .dev_done(dev_done),
    .dev_rdata(dev_rdata)
  );

  assign dev_work[0] = (mmio_addr == A_D0) || (mmio_addr == A_MM);
  assign dev_work[1] = (mmio_addr == A_D1);
  assign dev_work[2] = (mmio_addr == A_D2);
  assign dev_work[3] = (mmio_addr == A_D3) || (mmio_addr == A_MM);
  assign dev_done    = done_q | inj;
  assign dev_rdata   = {32'h3333_3333, 32'h0000_0001,
                        32'h0000_0011, 32'hA0A0_0000};

  always @(posedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      automatic logic hit = (mmio_read || mmio_write) && dev_work[i]
                            && !done_q[i] && !mute[i];
      done_q[i] <= hit;
      if (hit && mmio_write) wcnt[i]++;
      if (hit) ndone++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one access, drop req after acceptance and scramble the inputs
  task automatic run(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat,
                     output logic [31:0] rd, output logic er,
                     output int nrd, output int nwr);
    logic got;
    got = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rd = '0; er = 1'b0;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge sys_clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge sys_clk);
      if (k == 0) begin
        cpu_req = 1'b0; cpu_we = ~we;
        cpu_addr = 32'hDEAD_BEE0; cpu_wdata = 32'hFFFF_FFFF;
      end
      lat++;
      nrd += int'(mmio_read);
      nwr += int'(mmio_write);
      if (cpu_ready) begin
        got = 1'b1; rd = cpu_rdata; er = cpu_err;
        break;
      end
    end
    if (!got) chk("ready_wait", 32'd0, 32'd1);
  endtask

  int          lat, nrd, nwr, w1, w2, cyc, t1, t2, nrdy;
  logic [31:0] rd;
  logic        er;

  initial begin
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    rst_n = 1'b0;
    #23;
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_strobe", {30'd0, mmio_read, mmio_write}, 32'd0);
    chk("rst_addr", mmio_addr, 32'd0);
    chk("rst_rdata_err", cpu_rdata | {31'd0, cpu_err}, 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    run(1'b1, A_D1, 32'd1, lat, rd, er, nrd, nwr);
    chk("wr_lat", lat, 32'd3);
    chk("wr_err", {31'd0, er}, 32'd0);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_strobe_cyc", nwr, 32'd2);
    chk("wr_no_read", nrd, 32'd0);
    chk("wr_dev1_once", wcnt[1], 32'd1);

    run(1'b0, A_D2, 32'd0, lat, rd, er, nrd, nwr);
    chk("rd_lat", lat, 32'd3);
    chk("rd_data", rd, 32'h0000_0001);
    chk("rd_err", {31'd0, er}, 32'd0);
    chk("rd_strobe_cyc", nrd, 32'd2);

    w1 = ndone;
    run(1'b0, 32'h1234_0000, 32'd0, lat, rd, er, nrd, nwr);
    chk("um_lat", lat, 32'd2);
    chk("um_err", {31'd0, er}, 32'd1);
    chk("um_rdata", rd, 32'd0);
    chk("um_strobe_cyc", nrd, 32'd1);
    chk("um_no_done", ndone - w1, 32'd0);

    run(1'b1, 32'hFFFF_0082, 32'd7, lat, rd, er, nrd, nwr);
    chk("mis_lat", lat, 32'd1);
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_no_strobe", nrd + nwr, 32'd0);

    mute[1] = 1'b1;
    run(1'b0, A_D1, 32'd0, lat, rd, er, nrd, nwr);
    chk("to_lat", lat, 32'd17);
    chk("to_strobe_cyc", nrd, 32'd16);
    chk("to_err", {31'd0, er}, 32'd1);
    chk("to_rdata", rd, 32'd0);
    mute[1] = 1'b0;
    nrdy = 0;
    @(negedge sys_clk);
    inj[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      inj[1] = 1'b0;
      nrdy += int'(cpu_ready) + int'(mmio_read) + int'(mmio_write);
    end
    chk("late_done_ignored", nrdy, 32'd0);

    run(1'b0, A_MM, 32'd0, lat, rd, er, nrd, nwr);
    chk("mm_data", rd, 32'hA0A0_0000);
    chk("mm_err", {31'd0, er}, 32'd0);

    w1 = wcnt[1]; w2 = wcnt[2];
    cyc = 0; t1 = -1; t2 = -1;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = A_D1; cpu_wdata = 32'd5;
    for (int k = 0; k < 30 && t2 < 0; k++) begin
      @(negedge sys_clk);
      cyc++;
      if (cpu_ready) begin
        if (t1 < 0) begin
          t1 = cyc; cpu_addr = A_D2; cpu_wdata = 32'd6;
        end else begin
          t2 = cyc; cpu_req = 1'b0;
        end
      end
    end
    cpu_req = 1'b0;
    chk("b2b_gap", t2 - t1, 32'd4);
    chk("b2b_dev1_once", wcnt[1] - w1, 32'd1);
    chk("b2b_dev2_once", wcnt[2] - w2, 32'd1);

    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = A_D2; cpu_wdata = 32'd9;
    @(negedge sys_clk);
    cpu_req = 1'b0;
    chk("rst_mid_pre", {31'd0, mmio_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobe",
        {29'd0, cpu_ready, mmio_read, mmio_write}, 32'd0);
    chk("rst_mid_bus", mmio_addr | mmio_write_data, 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    nrdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      nrdy += int'(cpu_ready);
    end
    chk("rst_mid_no_ready", nrdy, 32'd0);

    run(1'b0, A_D2, 32'd0, lat, rd, er, nrd, nwr);
    chk("post_rst_lat", lat, 32'd3);
    chk("post_rst_data", rd, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
